// File: rtl/wb_ext_gateway_if.sv
// Bus bundle for the Wishbone gateway: upstream management slave port, downstream
// per-channel master port and timeout status. The gateway uses "slave", the environment "master".
interface wb_ext_gateway_if #(
    parameter int NUM_SLV = 4,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [DW/8-1:0]       wbs_sel_i;
    logic [AW-1:0]         wbs_adr_i;
    logic [DW-1:0]         wbs_dat_i;
    logic                  wbs_ack_o;
    logic                  wbs_err_o;
    logic [DW-1:0]         wbs_dat_o;

    logic [NUM_SLV-1:0]    wbm_cyc_o;
    logic [NUM_SLV-1:0]    wbm_stb_o;
    logic                  wbm_we_o;
    logic [DW/8-1:0]       wbm_sel_o;
    logic [AW-1:0]         wbm_adr_o;
    logic [DW-1:0]         wbm_dat_o;
    logic [NUM_SLV-1:0]    wbm_ack_i;
    logic [NUM_SLV-1:0]    wbm_err_i;
    logic [NUM_SLV*DW-1:0] wbm_dat_i;

    logic                  to_irq_o;
    logic [7:0]            to_cnt_o;
    logic [AW-1:0]         to_adr_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_err_i, wbm_dat_i,
        output to_irq_o, to_cnt_o, to_adr_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_err_i, wbm_dat_i,
        input  to_irq_o, to_cnt_o, to_adr_o
    );
endinterface

// File: rtl/wb_ext_gateway.sv
// Registered Wishbone gateway: decodes each management access onto one of NUM_SLV
// downstream channels and guarantees exactly one ack or err per transaction.
//
// state  | meaning
// IDLE   | waiting for upstream cyc & stb; latches the request
// REQ    | downstream cyc/stb on the decoded channel, timeout counting
// RESP   | one-cycle upstream ack or err pulse
module wb_ext_gateway #(
    parameter int NUM_SLV = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEC_LSB = 28,
    parameter int DEC_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_n,
    wb_ext_gateway_if.slave bus
);
    localparam int SW = DW / 8;
    localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t             r_state;
    logic [AW-1:0]      r_adr;
    logic [DW-1:0]      r_dat;
    logic [SW-1:0]      r_sel;
    logic               r_we;
    logic [IW-1:0]      r_idx;
    logic [NUM_SLV-1:0] r_chan;
    logic [CW-1:0]      r_cnt;
    logic               r_ack;
    logic               r_err;
    logic [DW-1:0]      r_rdat;
    logic               r_irq;
    logic [7:0]         r_to_cnt;
    logic [AW-1:0]      r_to_adr;

    logic [DEC_W-1:0]   w_field;
    logic               w_hit;
    logic               w_ack;
    logic               w_err;
    logic [DW-1:0]      w_rdat;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_timeout;

    assign w_field   = bus.wbs_adr_i[DEC_LSB +: DEC_W];
    assign w_hit     = int'(w_field) < NUM_SLV;
    assign w_ack     = bus.wbm_ack_i[r_idx];
    assign w_err     = bus.wbm_err_i[r_idx];
    // The comparison uses the post-increment count so TIMEOUT=N gives N strobe cycles.
    assign w_cnt_nxt = r_cnt + CW'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_nxt == TO_VAL);

    always_comb begin
        w_rdat = '0;
        for (int n = 0; n < NUM_SLV; n++) begin
            if (r_idx == IW'(n)) begin
                w_rdat = bus.wbm_dat_i[n*DW +: DW];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state  <= S_IDLE;
            r_adr    <= '0;
            r_dat    <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_idx    <= '0;
            r_chan   <= '0;
            r_cnt    <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdat   <= '0;
            r_irq    <= 1'b0;
            r_to_cnt <= '0;
            r_to_adr <= '0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                        r_adr <= bus.wbs_adr_i;
                        r_dat <= bus.wbs_dat_i;
                        r_sel <= bus.wbs_sel_i;
                        r_we  <= bus.wbs_we_i;
                        r_idx <= w_field[IW-1:0];
                        r_cnt <= '0;
                        if (w_hit) begin
                            r_chan  <= NUM_SLV'(1) << w_field;
                            r_state <= S_REQ;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= w_cnt_nxt;
                    if (!bus.wbs_cyc_i) begin
                        r_chan  <= '0;
                        r_state <= S_IDLE;
                    end else if (w_err) begin
                        r_chan  <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (w_ack) begin
                        r_chan  <= '0;
                        r_ack   <= 1'b1;
                        if (!r_we) begin
                            r_rdat <= w_rdat;
                        end
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_chan   <= '0;
                        r_err    <= 1'b1;
                        r_irq    <= 1'b1;
                        r_to_adr <= r_adr;
                        if (r_to_cnt != 8'hFF) begin
                            r_to_cnt <= r_to_cnt + 8'd1;
                        end
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdat  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_chan  <= '0;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdat  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wbs_ack_o = r_ack;
    assign bus.wbs_err_o = r_err;
    assign bus.wbs_dat_o = r_rdat;
    assign bus.wbm_cyc_o = r_chan;
    assign bus.wbm_stb_o = r_chan;
    assign bus.wbm_we_o  = r_we;
    assign bus.wbm_sel_o = r_sel;
    assign bus.wbm_adr_o = r_adr;
    assign bus.wbm_dat_o = r_dat;
    assign bus.to_irq_o  = r_irq;
    assign bus.to_cnt_o  = r_to_cnt;
    assign bus.to_adr_o  = r_to_adr;
endmodule

// File: tb/tb_wb_ext_gateway.sv
// Directed bench for wb_ext_gateway (NUM_SLV=4, TIMEOUT=8): a vector table of single
// transactions plus hand sequences for abort, timeout saturation and mid-request reset.
module tb_wb_ext_gateway;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wb_ext_gateway_if #(.NUM_SLV(4), .AW(32), .DW(32)) bif ();

    wb_ext_gateway #(
        .NUM_SLV(4), .AW(32), .DW(32), .DEC_LSB(28), .DEC_W(4), .TIMEOUT(8)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_n(rst_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          rch;    // responding channel
        logic [1:0]  kind;   // bit0 ack, bit1 err, 0 = silent
        int          rdly;   // respond in this strobe cycle (1 = first)
        logic [31:0] rdat;
        int          dch;    // distractor channel acking/erring every cycle, -1 none
        logic [3:0]  xstb;
        logic        xack;
        logic        xerr;
        logic [31:0] xdat;
        logic        xirq;
        int          xlat;   // edges from stb sample to visible response
        int          xscnt;  // downstream strobe cycles
    } vec_t;

    vec_t vt[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic clear_slaves();
        bif.wbm_ack_i = '0;
        bif.wbm_err_i = '0;
        bif.wbm_dat_i = '0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int          lat;
        int          scnt;
        logic        got;
        logic [3:0]  fstb;
        logic [31:0] fadr;
        logic [31:0] fdat;
        logic        rack;
        logic        rerr;
        logic        rirq;
        logic [31:0] rdat;
        bif.wbs_cyc_i = 1'b1;
        bif.wbs_stb_i = 1'b1;
        bif.wbs_we_i  = v.we;
        bif.wbs_adr_i = v.adr;
        bif.wbs_dat_i = v.dat;
        bif.wbs_sel_i = v.sel;
        tick();
        lat = 1; scnt = 0; got = 1'b0;
        fstb = '0; fadr = '0; fdat = '0;
        rack = 1'b0; rerr = 1'b0; rirq = 1'b0; rdat = '0;
        while (!got && lat < 40) begin
            if (bif.wbs_ack_o || bif.wbs_err_o) begin
                got  = 1'b1;
                rack = bif.wbs_ack_o;
                rerr = bif.wbs_err_o;
                rirq = bif.to_irq_o;
                rdat = bif.wbs_dat_o;
            end else begin
                if (bif.wbm_stb_o != '0) begin
                    scnt++;
                    if (scnt == 1) begin
                        fstb = bif.wbm_stb_o;
                        fadr = bif.wbm_adr_o;
                        fdat = bif.wbm_dat_o;
                    end
                end
                if (v.dch >= 0) begin
                    bif.wbm_ack_i[v.dch] = 1'b1;
                    bif.wbm_err_i[v.dch] = 1'b1;
                    bif.wbm_dat_i[v.dch*32 +: 32] = 32'hBAD0BAD0;
                end
                if (v.kind != 2'b00 && bif.wbm_stb_o != '0 && scnt == v.rdly) begin
                    bif.wbm_ack_i[v.rch] = v.kind[0];
                    bif.wbm_err_i[v.rch] = v.kind[1];
                    bif.wbm_dat_i[v.rch*32 +: 32] = v.rdat;
                end
                tick();
                lat++;
                clear_slaves();
            end
        end
        bif.wbs_cyc_i = 1'b0;
        bif.wbs_stb_i = 1'b0;
        chk({nm, "_responded"}, 32'(got), 32'd1);
        chk({nm, "_ack"}, 32'(rack), 32'(v.xack));
        chk({nm, "_err"}, 32'(rerr), 32'(v.xerr));
        chk({nm, "_rdata"}, rdat, v.xdat);
        chk({nm, "_irq"}, 32'(rirq), 32'(v.xirq));
        chk({nm, "_latency"}, 32'(lat), 32'(v.xlat));
        chk({nm, "_stb_cycles"}, 32'(scnt), 32'(v.xscnt));
        chk({nm, "_stb_onehot"}, 32'(fstb), 32'(v.xstb));
        if (v.xstb != 4'b0000) begin
            chk({nm, "_dn_adr"}, fadr, v.adr);
            chk({nm, "_dn_dat"}, fdat, v.dat);
        end
        tick();
        chk({nm, "_single_pulse"}, 32'({bif.wbs_ack_o, bif.wbs_err_o, bif.to_irq_o}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tv;
        logic flag;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bif.wbs_cyc_i = 1'b0;
        bif.wbs_stb_i = 1'b0;
        bif.wbs_we_i  = 1'b0;
        bif.wbs_sel_i = '0;
        bif.wbs_adr_i = '0;
        bif.wbs_dat_i = '0;
        clear_slaves();

        //       we  adr            dat            sel  rch kind rdly rdat           dch xstb     ack err xdat          irq lat scnt
        vt[0] = '{1'b1, 32'h1000_0004, 32'hDEADBEEF, 4'hF, 1, 2'd1, 1, 32'h0000_0000, -1, 4'b0010, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 2, 1};
        vt[1] = '{1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 3, 2'd1, 5, 32'h1234_5678, -1, 4'b1000, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 6, 5};
        vt[2] = '{1'b1, 32'h5000_0000, 32'h1111_1111, 4'h3, 0, 2'd0, 0, 32'h0000_0000, -1, 4'b0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1, 0};
        vt[3] = '{1'b0, 32'h2000_0010, 32'h0000_0000, 4'hF, 2, 2'd0, 0, 32'h0000_0000, -1, 4'b0100, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 9, 8};
        vt[4] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'hF, 0, 2'd3, 2, 32'hAAAA_5555, -1, 4'b0001, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 3, 2};
        vt[5] = '{1'b0, 32'h0000_0080, 32'h0000_0000, 4'hF, 0, 2'd1, 3, 32'hCAFE_F00D,  1, 4'b0001, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 4, 3};
        vt[6] = '{1'b0, 32'h2000_0020, 32'h0000_0000, 4'hF, 2, 2'd1, 8, 32'h0BAD_C0DE, -1, 4'b0100, 1'b1, 1'b0, 32'h0BAD_C0DE, 1'b0, 9, 8};
        vt[7] = '{1'b0, 32'hF000_0000, 32'h0000_0000, 4'hF, 0, 2'd0, 0, 32'h0000_0000, -1, 4'b0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1, 0};
        vt[8] = '{1'b0, 32'h2000_0000, 32'h0000_0000, 4'hF, 2, 2'd2, 4, 32'h55AA_55AA, -1, 4'b0100, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 5, 4};
        vt[9] = '{1'b1, 32'h1000_0008, 32'h0F0F_0F0F, 4'h5, 1, 2'd1, 2, 32'h7777_7777,  3, 4'b0010, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 3, 2};

        // Reset state
        tick();
        tick();
        chk("rst_ack_err", 32'({bif.wbs_ack_o, bif.wbs_err_o}), 32'd0);
        chk("rst_dat_o", bif.wbs_dat_o, 32'd0);
        chk("rst_stb_cyc", 32'({bif.wbm_stb_o, bif.wbm_cyc_o}), 32'd0);
        chk("rst_dn_adr", bif.wbm_adr_o, 32'd0);
        chk("rst_to_cnt", 32'(bif.to_cnt_o), 32'd0);
        chk("rst_to_adr", bif.to_adr_o, 32'd0);
        chk("rst_irq", 32'(bif.to_irq_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i], $sformatf("v%0d", i));
        end
        chk("to_cnt_after_table", 32'(bif.to_cnt_o), 32'd1);
        chk("to_adr_after_table", bif.to_adr_o, 32'h2000_0010);

        // Abort: drop cyc two cycles into REQ
        bif.wbs_cyc_i = 1'b1;
        bif.wbs_stb_i = 1'b1;
        bif.wbs_we_i  = 1'b0;
        bif.wbs_adr_i = 32'h1000_0000;
        tick();
        chk("abort_stb_up", 32'(bif.wbm_stb_o), 32'h2);
        tick();
        bif.wbs_cyc_i = 1'b0;
        bif.wbs_stb_i = 1'b0;
        tick();
        chk("abort_stb_dropped", 32'({bif.wbm_stb_o, bif.wbm_cyc_o}), 32'd0);
        flag = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bif.wbs_ack_o || bif.wbs_err_o || bif.to_irq_o || bif.wbm_stb_o != '0) flag = 1'b1;
            tick();
        end
        chk("abort_no_response", 32'(flag), 32'd0);
        chk("abort_to_cnt", 32'(bif.to_cnt_o), 32'd1);

        // Timeout counter saturation
        tv = vt[3];
        for (int k = 0; k < 300; k++) begin
            tv.adr = 32'h2000_0000 + 32'(k * 16);
            run_vec(tv, $sformatf("sat%0d", k));
            if (k == 9) chk("to_cnt_after_11", 32'(bif.to_cnt_o), 32'd11);
        end
        chk("to_cnt_saturated", 32'(bif.to_cnt_o), 32'd255);
        chk("to_adr_last", bif.to_adr_o, 32'h2000_12B0);

        // Asynchronous reset in the middle of a request
        bif.wbs_cyc_i = 1'b1;
        bif.wbs_stb_i = 1'b1;
        bif.wbs_we_i  = 1'b1;
        bif.wbs_adr_i = 32'h3000_0044;
        bif.wbs_dat_i = 32'hA5A5_A5A5;
        tick();
        tick();
        chk("mrst_stb_before", 32'(bif.wbm_stb_o), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_stb_cyc", 32'({bif.wbm_stb_o, bif.wbm_cyc_o}), 32'd0);
        chk("mrst_ack_err", 32'({bif.wbs_ack_o, bif.wbs_err_o, bif.to_irq_o}), 32'd0);
        chk("mrst_dn_adr_dat", bif.wbm_adr_o | bif.wbm_dat_o, 32'd0);
        chk("mrst_to_cnt", 32'(bif.to_cnt_o), 32'd0);
        chk("mrst_to_adr", bif.to_adr_o, 32'd0);
        bif.wbs_cyc_i = 1'b0;
        bif.wbs_stb_i = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bif.wbs_ack_o || bif.wbs_err_o || bif.wbm_stb_o != '0) flag = 1'b1;
        end
        chk("mrst_stays_idle", 32'(flag), 32'd0);
        run_vec(vt[1], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
